// File: rtl/cic_decim_serial_comb_if.sv
// Sample-stream bundle between the upstream source, the CIC decimator and
// the downstream compensation filter.
interface cic_decim_serial_comb_if #(
    parameter int DW_IN  = 16,
    parameter int DW_OUT = 12
);
    logic                     clk_enable;
    logic signed [DW_IN-1:0]  filter_in;
    logic signed [DW_OUT-1:0] filter_out;
    logic                     ce_out;

    modport master (
        output clk_enable,
        output filter_in,
        input  filter_out,
        input  ce_out
    );

    modport slave (
        input  clk_enable,
        input  filter_in,
        output filter_out,
        output ce_out
    );
endinterface

// File: rtl/cic_decim_serial_comb.sv
// N-stage CIC decimator (differential delay 1). Integrators run at the input
// strobe rate; the comb section is evaluated once per R inputs by a single
// time-shared subtractor, one stage per clock, then rounded and saturated.
module cic_decim_serial_comb #(
    parameter int DW_IN  = 16,
    parameter int DW_OUT = 12,
    parameter int R      = 25,
    parameter int N      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    cic_decim_serial_comb_if.slave        bus
);
    localparam int CW     = $clog2(R);
    localparam int DW_ACC = DW_IN + N * CW;
    localparam int D      = DW_ACC - DW_OUT;
    localparam int KW     = (N > 1) ? $clog2(N) : 1;

    localparam logic [DW_ACC:0]   HALF    = (DW_ACC + 1)'(1) << (D - 1);
    localparam logic [DW_OUT-1:0] OUT_MAX = {1'b0, {(DW_OUT - 1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMB,
        OUT
    } state_t;

    state_t state, state_nx;

    logic [DW_ACC-1:0] integ [N];
    logic [DW_ACC-1:0] dly   [N];
    logic [DW_ACC-1:0] work;
    logic [DW_ACC-1:0] diff;
    logic [DW_ACC:0]   rnd_sum;
    logic [DW_OUT-1:0] rnd_sat;
    logic [CW-1:0]     dec_cnt;
    logic [KW-1:0]     k_cnt;
    logic              tick;
    logic              last_stage;

    assign tick       = bus.clk_enable && (dec_cnt == CW'(R - 1));
    assign last_stage = (state == COMB) && (k_cnt == KW'(N - 1));

    // Shared comb subtractor and round-half-up / positive saturation of its result.
    always_comb begin
        diff    = work - dly[k_cnt];
        rnd_sum = {diff[DW_ACC-1], diff} + HALF;
        rnd_sat = rnd_sum[DW_ACC-1:D];
        if (!diff[DW_ACC-1] && (rnd_sum[DW_ACC] || rnd_sum[DW_ACC-1])) begin
            rnd_sat = OUT_MAX;
        end
    end

    // Integrator chain (registered, wrapping) and decimation counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
            dec_cnt <= '0;
        end else if (bus.clk_enable) begin
            integ[0] <= integ[0] + {{(DW_ACC - DW_IN){bus.filter_in[DW_IN-1]}}, bus.filter_in};
            for (int unsigned k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
            dec_cnt <= (dec_cnt == CW'(R - 1)) ? '0 : dec_cnt + CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; a tick arriving while busy is ignored.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = LOAD;
            LOAD:    state_nx = COMB;
            COMB:    if (last_stage) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Comb datapath and output register.
    // The rounded result is registered on the last comb clock so that filter_out
    // and ce_out change on the same edge and ce_out is high during OUT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                dly[k] <= '0;
            end
            k_cnt          <= '0;
            bus.filter_out <= '0;
            bus.ce_out     <= 1'b0;
        end else begin
            bus.ce_out <= 1'b0;
            case (state)
                LOAD: begin
                    work  <= integ[N-1];
                    k_cnt <= '0;
                end
                COMB: begin
                    work       <= diff;
                    dly[k_cnt] <= work;
                    k_cnt      <= k_cnt + KW'(1);
                    if (last_stage) begin
                        bus.filter_out <= rnd_sat;
                        bus.ce_out     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cic_decim_serial_comb.sv
// Directed bench for the serial-comb CIC decimator (R=25, N=4, 16 -> 12 bits).
module tb_cic_decim_serial_comb;
    logic clk;
    logic reset_n;

    cic_decim_serial_comb_if #(.DW_IN(16), .DW_OUT(12)) bif ();

    cic_decim_serial_comb #(
        .DW_IN (16),
        .DW_OUT(12),
        .R     (25),
        .N     (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] din;
        int                 gap;
        int                 steady;
    } vec_t;

    vec_t tbl [7];
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   hold_err;
    int   c25;
    int   last_fo;
    int   ce_cyc [$];
    int   ce_val [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample outputs of the previous edge, then drive inputs for the next edge.
    task automatic step(input logic en, input logic signed [15:0] d, input logic rn);
        @(negedge clk);
        cyc++;
        if (bif.ce_out === 1'b1) begin
            ce_cyc.push_back(cyc);
            ce_val.push_back(int'(bif.filter_out));
            last_fo = int'(bif.filter_out);
        end else if (int'(bif.filter_out) != last_fo) begin
            hold_err++;
        end
        bif.clk_enable = en;
        bif.filter_in  = d;
        reset_n        = rn;
    endtask

    task automatic do_reset(input string tag);
        repeat (5) step(1'b0, '0, 1'b0);
        check({tag, " reset filter_out"}, longint'(bif.filter_out), 0);
        check({tag, " reset ce_out"}, longint'(bif.ce_out), 0);
        ce_cyc.delete();
        ce_val.delete();
        cyc      = 0;
        hold_err = 0;
        last_fo  = 0;
    endtask

    // Constant input with a strobe every 'gap' clocks; records the 25th strobe cycle.
    task automatic run_seq(input logic signed [15:0] d, input int gap, input int ncyc);
        int sc;
        sc = 0;
        for (int i = 0; i < ncyc; i++) begin
            logic en;
            en = ((i % gap) == 0);
            step(en, d, 1'b1);
            if (en) begin
                sc++;
                if (sc == 25) c25 = cyc;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        hold_err = 0;
        last_fo = 0;
        c25 = -1;
        reset_n = 1'b0;
        bif.clk_enable = 1'b0;
        bif.filter_in  = '0;

        // steady = round(din * 25^4 / 2^24), half up
        tbl[0] = '{din: 16'sd16384,  gap: 1, steady: 381};
        tbl[1] = '{din: -16'sd32768, gap: 1, steady: -763};
        tbl[2] = '{din: 16'sd32767,  gap: 1, steady: 763};
        tbl[3] = '{din: 16'sd16384,  gap: 3, steady: 381};
        tbl[4] = '{din: -16'sd16384, gap: 2, steady: -381};
        tbl[5] = '{din: 16'sd1000,   gap: 1, steady: 23};
        tbl[6] = '{din: -16'sd1,     gap: 1, steady: 0};

        for (int v = 0; v < 7; v++) begin
            string  tag;
            longint first_exp;
            tag = $sformatf("vec%0d", v);
            do_reset(tag);
            c25 = -1;
            run_seq(tbl[v].din, tbl[v].gap, 25 * tbl[v].gap * 8 + 10);
            // First output sees 22 samples through h[0..21], whose sum is C(25,4)=12650.
            first_exp = (longint'(tbl[v].din) * 12650 + 64'sd8388608) >>> 24;
            check({tag, " output count>=7"}, longint'(ce_cyc.size() >= 7), 1);
            if (ce_cyc.size() >= 7) begin
                check({tag, " first ce latency"}, longint'(ce_cyc[0] - c25), 6);
                check({tag, " first value"}, longint'(ce_val[0]), first_exp);
                for (int j = 4; j < 7; j++) begin
                    check($sformatf("%s steady[%0d]", tag, j), longint'(ce_val[j]),
                          longint'(tbl[v].steady));
                    check($sformatf("%s spacing[%0d]", tag, j),
                          longint'(ce_cyc[j] - ce_cyc[j-1]), longint'(25 * tbl[v].gap));
                end
            end
            check({tag, " filter_out held"}, longint'(hold_err), 0);
        end

        // Impulse of 16384: outputs are h[21], h[46], h[71], h[96] / 1024, rounded.
        begin
            int exp_imp [8];
            int sum;
            exp_imp = '{2, 10, 3, 0, 0, 0, 0, 0};
            do_reset("impulse");
            step(1'b1, 16'sd16384, 1'b1);
            for (int i = 0; i < 25 * 8 + 10; i++) step(1'b1, '0, 1'b1);
            check("impulse output count>=8", longint'(ce_val.size() >= 8), 1);
            if (ce_val.size() >= 8) begin
                sum = 0;
                for (int j = 0; j < 8; j++) begin
                    sum += ce_val[j];
                    check($sformatf("impulse out[%0d]", j), longint'(ce_val[j]),
                          longint'(exp_imp[j]));
                end
                check("impulse sum in [11,19]", longint'(sum >= 11 && sum <= 19), 1);
            end
        end

        // Reset asserted the clock after the tick edge: computation aborted, no ce_out.
        begin
            int cnt_before;
            do_reset("midcomb");
            c25 = -1;
            run_seq(16'sd16384, 1, 25);
            check("midcomb tick reached", longint'(c25), 25);
            cnt_before = ce_cyc.size();
            repeat (4) step(1'b0, '0, 1'b0);
            check("midcomb filter_out after reset", longint'(bif.filter_out), 0);
            repeat (12) step(1'b0, '0, 1'b1);
            check("midcomb no ce_out", longint'(ce_cyc.size() - cnt_before), 0);
            check("midcomb filter_out idle", longint'(bif.filter_out), 0);
            ce_cyc.delete();
            ce_val.delete();
            cyc = 0;
            c25 = -1;
            run_seq(16'sd16384, 1, 25 + 10);
            check("midcomb restart count", longint'(ce_cyc.size()), 1);
            if (ce_cyc.size() >= 1) begin
                check("midcomb restart latency", longint'(ce_cyc[0] - c25), 6);
                check("midcomb restart value", longint'(ce_val[0]), 12);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
